// File: rtl/simple_system_onchip_ram_dp_if.sv
// Avalon-MM slave bundle for one port of the dual-port on-chip RAM.
// The master modport is the CPU/DMA side; the slave modport is the RAM side.
interface simple_system_onchip_ram_dp_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/simple_system_onchip_ram_dp.sv
// True-dual-port Avalon-MM on-chip RAM with byte enables and 1/2-cycle read latency.
// Define SIMPLE_SYSTEM_ONCHIP_RAM_CLEAR_EN to compile in the post-reset zero-fill sweep.
module simple_system_onchip_ram_dp #(
    parameter int    DATA_W       = 64,
    parameter int    ADDR_W       = 13,
    parameter int    DEPTH        = 8192,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "simple_system_onchip_ram_dp.hex"
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_reset_req,
    input  logic                         i_clken,
    simple_system_onchip_ram_dp_if.slave s1,
    simple_system_onchip_ram_dp_if.slave s2
);
    localparam int              BE_W    = DATA_W / 8;
    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Port 0 is s1, port 1 is s2.
    logic [ADDR_W-1:0] w_addr     [2];
    logic              w_cs       [2];
    logic              w_rd       [2];
    logic              w_wr       [2];
    logic [BE_W-1:0]   w_be       [2];
    logic [DATA_W-1:0] w_wdata    [2];
    logic [DATA_W-1:0] w_rdata    [2];
    logic              w_rvalid   [2];

    logic              w_wr_acc   [2];
    logic              w_rd_acc   [2];
    logic              w_in_range [2];
    logic [MEM_AW-1:0] w_ridx     [2];

    logic              w_we       [2];
    logic [MEM_AW-1:0] w_widx     [2];
    logic [BE_W-1:0]   w_wbe      [2];
    logic [DATA_W-1:0] w_wdat     [2];

    logic              w_stall;
    logic              w_clearing;

    assign w_addr[0]  = s1.address;
    assign w_cs[0]    = s1.chipselect;
    assign w_rd[0]    = s1.read;
    assign w_wr[0]    = s1.write;
    assign w_be[0]    = s1.byteenable;
    assign w_wdata[0] = s1.writedata;
    assign w_addr[1]  = s2.address;
    assign w_cs[1]    = s2.chipselect;
    assign w_rd[1]    = s2.read;
    assign w_wr[1]    = s2.write;
    assign w_be[1]    = s2.byteenable;
    assign w_wdata[1] = s2.writedata;

    assign s1.readdata      = w_rdata[0];
    assign s1.readdatavalid = w_rvalid[0];
    assign s1.waitrequest   = w_stall;
    assign s2.readdata      = w_rdata[1];
    assign s2.readdatavalid = w_rvalid[1];
    assign s2.waitrequest   = w_stall;

    // Reset is folded in so waitrequest rises immediately, not at the next edge.
    assign w_stall = i_reset | i_reset_req | ~i_clken | w_clearing;

`ifdef SIMPLE_SYSTEM_ONCHIP_RAM_CLEAR_EN
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } clr_state_t;

    clr_state_t       r_state;
    clr_state_t       w_state_next;
    logic [CNT_W-1:0] r_clr_cnt;
    logic [CNT_W-1:0] w_clr_cnt_next;
    logic             w_clr_step;

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_clr_step = (r_state == S_CLEAR) & ~i_reset & ~i_reset_req & i_clken;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clearing     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clearing = 1'b1;
                if (w_clr_step) begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                    if (r_clr_cnt == CNT_W'(DEPTH - 1)) begin
                        w_state_next = S_READY;
                    end
                end
            end
            S_READY: begin
                w_state_next = S_READY;
            end
            default: begin
                w_state_next = S_CLEAR;
            end
        endcase
    end

    // The sweep borrows the s1 write path; s1 itself is stalled meanwhile.
    assign w_we[0]   = w_clearing ? w_clr_step : (w_wr_acc[0] & w_in_range[0]);
    assign w_widx[0] = w_clearing ? MEM_AW'(r_clr_cnt) : MEM_AW'(w_addr[0]);
    assign w_wbe[0]  = w_clearing ? {BE_W{1'b1}} : w_be[0];
    assign w_wdat[0] = w_clearing ? '0 : w_wdata[0];
`else
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_clearing = 1'b0;
    assign w_we[0]    = w_wr_acc[0] & w_in_range[0];
    assign w_widx[0]  = MEM_AW'(w_addr[0]);
    assign w_wbe[0]   = w_be[0];
    assign w_wdat[0]  = w_wdata[0];
`endif

    assign w_we[1]   = w_wr_acc[1] & w_in_range[1];
    assign w_widx[1] = MEM_AW'(w_addr[1]);
    assign w_wbe[1]  = w_be[1];
    assign w_wdat[1] = w_wdata[1];

    // s2 is applied first so s1 overrides every byte both ports enable.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (w_we[1] && w_wbe[1][b]) begin
                r_mem[w_widx[1]][b*8 +: 8] <= w_wdat[1][b*8 +: 8];
            end
            if (w_we[0] && w_wbe[0][b]) begin
                r_mem[w_widx[0]][b*8 +: 8] <= w_wdat[0][b*8 +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              w_acc;
        logic              w_vld_out;
        logic              w_oor_out;
        logic [DATA_W-1:0] w_dat_out;
        logic [DATA_W-1:0] r_rdata_q;

        assign w_acc          = w_cs[gi] & (w_rd[gi] | w_wr[gi]) & ~w_stall;
        assign w_wr_acc[gi]   = w_acc & w_wr[gi];
        assign w_rd_acc[gi]   = w_acc & w_rd[gi] & ~w_wr[gi];
        assign w_in_range[gi] = ({1'b0, w_addr[gi]} < DEPTH_C);
        assign w_ridx[gi]     = w_in_range[gi] ? MEM_AW'(w_addr[gi]) : '0;

        // Registered read samples the pre-write contents on a same-edge write.
        always_ff @(posedge i_clk) begin
            if (w_rd_acc[gi]) begin
                r_rdata_q <= r_mem[w_ridx[gi]];
            end
        end

        if (READ_LATENCY == 1) begin : g_lat1
            logic r_vld1;
            logic r_oor1;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_vld1 <= 1'b0;
                    r_oor1 <= 1'b0;
                end else begin
                    r_vld1 <= w_rd_acc[gi];
                    r_oor1 <= ~w_in_range[gi];
                end
            end

            assign w_vld_out = r_vld1;
            assign w_oor_out = r_oor1;
            assign w_dat_out = r_rdata_q;
        end else begin : g_lat2
            logic              r_vld1;
            logic              r_vld2;
            logic              r_oor1;
            logic              r_oor2;
            logic [DATA_W-1:0] r_rdata_d;

            // Not gated by clken or stall: in-flight reads always drain.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_vld1    <= 1'b0;
                    r_vld2    <= 1'b0;
                    r_oor1    <= 1'b0;
                    r_oor2    <= 1'b0;
                    r_rdata_d <= '0;
                end else begin
                    r_vld1    <= w_rd_acc[gi];
                    r_vld2    <= r_vld1;
                    r_oor1    <= ~w_in_range[gi];
                    r_oor2    <= r_oor1;
                    r_rdata_d <= r_rdata_q;
                end
            end

            assign w_vld_out = r_vld2;
            assign w_oor_out = r_oor2;
            assign w_dat_out = r_rdata_d;
        end

        assign w_rvalid[gi] = w_vld_out;
        assign w_rdata[gi]  = (w_vld_out & ~w_oor_out) ? w_dat_out : '0;
    end
endmodule

// File: tb/tb_simple_system_onchip_ram_dp.sv
// Scoreboard bench: two RAM instances (READ_LATENCY 1 and 2), four slave channels.
// Channels 0/1 are s1/s2 of the latency-1 RAM, channels 2/3 of the latency-2 RAM.
module tb_simple_system_onchip_ram_dp;
    localparam int DW    = 64;
    localparam int AW    = 13;
    localparam int DEPTH = 16;
`ifdef SIMPLE_SYSTEM_ONCHIP_RAM_CLEAR_EN
    localparam int SWEEP = 16;
`else
    localparam int SWEEP = 0;
`endif

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic reset_req = 1'b0;
    logic clken     = 1'b1;
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_bad     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] m_addr [4];
    logic          m_cs   [4];
    logic          m_rd   [4];
    logic          m_wr   [4];
    logic [7:0]    m_be   [4];
    logic [DW-1:0] m_wd   [4];
    logic [DW-1:0] p_exp  [4];
    logic [DW-1:0] s_rd   [4];
    logic          s_rv   [4];
    logic          s_wait [4];

    simple_system_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_bus
        assign bus[g].address    = m_addr[g];
        assign bus[g].chipselect = m_cs[g];
        assign bus[g].read       = m_rd[g];
        assign bus[g].write      = m_wr[g];
        assign bus[g].byteenable = m_be[g];
        assign bus[g].writedata  = m_wd[g];
        assign s_rd[g]           = bus[g].readdata;
        assign s_rv[g]           = bus[g].readdatavalid;
        assign s_wait[g]         = bus[g].waitrequest;
    end

    simple_system_onchip_ram_dp #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1)
    ) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_reset_req(reset_req), .i_clken(clken),
        .s1(bus[0]), .s2(bus[1])
    );

    simple_system_onchip_ram_dp #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2)
    ) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_reset_req(reset_req), .i_clken(clken),
        .s1(bus[2]), .s2(bus[3])
    );

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    exp_t sb [4][$];

    function automatic int lat(input int ch);
        return (ch < 2) ? 1 : 2;
    endfunction

    function automatic logic [DW-1:0] tp_data(input int i);
        return {32'hA5A5_0000 | 32'(i), 32'h0F0F_0000 | 32'(i)};
    endfunction

    // Monitor: every valid pulse must match the oldest expectation, in data and cycle.
    always @(negedge clk) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (s_rv[ch] === 1'b1) begin
                n_vec++;
                if (sb[ch].size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid ch%0d: got valid data %h at cycle %0d, required no valid",
                             ch, s_rd[ch], cyc);
                end else begin
                    exp_t e;
                    e = sb[ch].pop_front();
                    if (s_rd[ch] !== e.d || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL read ch%0d: got %h at cycle %0d, required %h at cycle %0d",
                                 ch, s_rd[ch], cyc, e.d, e.cyc);
                    end else begin
                        $display("ok read ch%0d: %h at cycle %0d", ch, s_rd[ch], cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end else begin
            $display("ok %s: %h", nm, act);
        end
    endtask

    task automatic cmd(input int ch, input bit rd, input bit wr, input int a,
                       input logic [7:0] be, input logic [DW-1:0] wd, input logic [DW-1:0] ex);
        m_cs[ch]   = 1'b1;
        m_rd[ch]   = rd;
        m_wr[ch]   = wr;
        m_addr[ch] = AW'(a);
        m_be[ch]   = be;
        m_wd[ch]   = wd;
        p_exp[ch]  = ex;
    endtask

    // Issue all staged commands on the coming edge; reads push their expectation.
    task automatic fire();
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            if (m_cs[ch]) begin
                chk($sformatf("accept_ch%0d", ch), 64'(s_wait[ch]), 64'd0);
                if (m_rd[ch] && !m_wr[ch]) begin
                    exp_t e;
                    e.d   = p_exp[ch];
                    e.cyc = cyc + lat(ch);
                    sb[ch].push_back(e);
                end
            end
        end
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            m_cs[ch] = 1'b0;
            m_rd[ch] = 1'b0;
            m_wr[ch] = 1'b0;
        end
    endtask

    task automatic count_wait(input string nm);
        int n;
        n = 0;
        #1;
        while (s_wait[0] === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk(nm, 64'(n), 64'(SWEEP));
        chk({nm, "_l2"}, 64'(s_wait[2]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            m_cs[ch] = 1'b0; m_rd[ch] = 1'b0; m_wr[ch] = 1'b0;
            m_addr[ch] = '0; m_be[ch] = '0; m_wd[ch] = '0; p_exp[ch] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("rst_wait_ch%0d", ch), 64'(s_wait[ch]), 64'd1);
            chk($sformatf("rst_valid_ch%0d", ch), 64'(s_rv[ch]), 64'd0);
            chk($sformatf("rst_data_ch%0d", ch), s_rd[ch], 64'd0);
        end

        @(negedge clk);
        rst = 1'b0;
        count_wait("sweep_len");

        // Reset lands while a latency-2 read is in flight: its valid must vanish.
        @(negedge clk);
        m_cs[3] = 1'b1; m_rd[3] = 1'b1; m_addr[3] = '0;
        @(negedge clk);
        m_cs[3] = 1'b0; m_rd[3] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_wait("sweep_restart_len");

`ifdef SIMPLE_SYSTEM_ONCHIP_RAM_CLEAR_EN
        for (int a = 0; a < DEPTH; a++) begin
            cmd(0, 1, 0, a, 8'h00, '0, 64'd0);
            cmd(3, 1, 0, a, 8'h00, '0, 64'd0);
            fire();
        end
`endif

        // Full write then read, both latencies
        cmd(0, 0, 1, 5, 8'hFF, 64'h0123456789ABCDEF, '0);
        cmd(2, 0, 1, 5, 8'hFF, 64'h0123456789ABCDEF, '0);
        cmd(1, 0, 1, 0, 8'hFF, 64'hCAFEF00D12345678, '0);
        cmd(3, 0, 1, 0, 8'hFF, 64'hCAFEF00D12345678, '0);
        fire();
        cmd(0, 1, 0, 5, 8'h00, '0, 64'h0123456789ABCDEF);
        cmd(2, 1, 0, 5, 8'h00, '0, 64'h0123456789ABCDEF);
        fire();

        // Partial byte enables from s2, seen by s1 on the next edge
        cmd(1, 0, 1, 5, 8'h0F, 64'hFFFFFFFFFFFFFFFF, '0);
        cmd(3, 0, 1, 5, 8'h0F, 64'hFFFFFFFFFFFFFFFF, '0);
        fire();
        cmd(0, 1, 0, 5, 8'h00, '0, 64'h01234567FFFFFFFF);
        cmd(2, 1, 0, 5, 8'h00, '0, 64'h01234567FFFFFFFF);
        fire();

        // Same-address collision
        cmd(0, 0, 1, 9, 8'hF0, 64'hAAAAAAAAAAAAAAAA, '0);
        cmd(1, 0, 1, 9, 8'hFF, 64'h5555555555555555, '0);
        cmd(2, 0, 1, 9, 8'hF0, 64'hAAAAAAAAAAAAAAAA, '0);
        cmd(3, 0, 1, 9, 8'hFF, 64'h5555555555555555, '0);
        fire();
        cmd(1, 1, 0, 9, 8'h00, '0, 64'hAAAAAAAA55555555);
        cmd(3, 1, 0, 9, 8'h00, '0, 64'hAAAAAAAA55555555);
        fire();

        // Mixed-port read-during-write returns old data
        cmd(0, 0, 1, 9, 8'hFF, 64'h1111111111111111, '0);
        cmd(1, 1, 0, 9, 8'h00, '0, 64'hAAAAAAAA55555555);
        cmd(2, 0, 1, 9, 8'hFF, 64'h1111111111111111, '0);
        cmd(3, 1, 0, 9, 8'h00, '0, 64'hAAAAAAAA55555555);
        fire();
        cmd(1, 1, 0, 9, 8'h00, '0, 64'h1111111111111111);
        cmd(3, 1, 0, 9, 8'h00, '0, 64'h1111111111111111);
        fire();

        // Out-of-range: write dropped (address 0 would alias), read returns zero
        cmd(0, 0, 1, DEPTH, 8'hFF, 64'hDEADBEEFDEADBEEF, '0);
        cmd(2, 0, 1, DEPTH, 8'hFF, 64'hDEADBEEFDEADBEEF, '0);
        fire();
        cmd(0, 1, 0, DEPTH, 8'h00, '0, 64'd0);
        cmd(1, 1, 0, 0, 8'h00, '0, 64'hCAFEF00D12345678);
        cmd(2, 1, 0, DEPTH, 8'h00, '0, 64'd0);
        cmd(3, 1, 0, 0, 8'h00, '0, 64'hCAFEF00D12345678);
        fire();

        // Read+write together is a write with no valid
        cmd(0, 1, 1, 3, 8'hFF, 64'h3333333333333333, '0);
        cmd(2, 1, 1, 3, 8'hFF, 64'h3333333333333333, '0);
        fire();
        cmd(0, 1, 0, 3, 8'h00, '0, 64'h3333333333333333);
        cmd(2, 1, 0, 3, 8'h00, '0, 64'h3333333333333333);
        fire();

        // byteenable = 0 leaves the word untouched
        cmd(1, 0, 1, 3, 8'h00, 64'hFFFFFFFFFFFFFFFF, '0);
        cmd(3, 0, 1, 3, 8'h00, 64'hFFFFFFFFFFFFFFFF, '0);
        fire();
        cmd(1, 1, 0, 3, 8'h00, '0, 64'h3333333333333333);
        cmd(3, 1, 0, 3, 8'h00, '0, 64'h3333333333333333);
        fire();

        // clken low for 3 cycles with a held read: one valid after release
        cmd(0, 1, 0, 5, 8'h00, '0, 64'h01234567FFFFFFFF);
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("clken_stall_%0d", i), 64'(s_wait[0]), 64'd1);
            @(negedge clk);
        end
        clken = 1'b1;
        fire();

        reset_req = 1'b1;
        #1;
        chk("reset_req_wait_s2", 64'(s_wait[1]), 64'd1);
        chk("reset_req_wait_l2", 64'(s_wait[3]), 64'd1);
        @(negedge clk);
        reset_req = 1'b0;

        // Back-to-back throughput
        for (int i = 0; i < 8; i++) begin
            cmd(0, 0, 1, i, 8'hFF, tp_data(i), '0);
            cmd(2, 0, 1, i, 8'hFF, tp_data(i), '0);
            fire();
        end
        for (int i = 0; i < 8; i++) begin
            cmd(0, 1, 0, i, 8'h00, '0, tp_data(i));
            cmd(1, 1, 0, 7 - i, 8'h00, '0, tp_data(7 - i));
            cmd(2, 1, 0, i, 8'h00, '0, tp_data(i));
            cmd(3, 1, 0, 7 - i, 8'h00, '0, tp_data(7 - i));
            fire();
        end

        repeat (5) @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("pending_ch%0d", ch), 64'(sb[ch].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/simple_system_onchip_ram_dp.md
# simple_system_onchip_ram_dp

Parametrised true-dual-port Avalon-MM on-chip RAM for the simple_system fabric. Two independent slaves, s1 and s2, share one memory array. Each slave has byte enables, a configurable read latency with `readdatavalid` pipelining, and `waitrequest` back-pressure. An optional post-reset zero-fill sweep guarantees deterministic contents before the CPU or DMA touches the array.

## Interface
Parameters:
- DATA_W, 64: data width in bits; must be a multiple of 8.
- ADDR_W, 13: word address width.
- DEPTH, 8192: number of words; 1 ≤ DEPTH ≤ 2^ADDR_W.
- READ_LATENCY, 1: cycles from read acceptance to `readdatavalid`; legal values are 1 and 2.
- INIT_FILE, "simple_system_onchip_ram_dp.hex": initial contents, used only when the clear sweep is compiled out.

Ports (x = 1, 2, one identical set per slave):
- clk  in  1  single clock for both ports and all state.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  synchronous hold request; stalls both ports while high.
- clken  in  1  global clock enable; stalls both ports while low.
- sx_address  in  ADDR_W  word address.
- sx_chipselect  in  1  slave select.
- sx_read  in  1  read request.
- sx_write  in  1  write request.
- sx_byteenable  in  DATA_W/8  per-byte write enable.
- sx_writedata  in  DATA_W  write data.
- sx_readdata  out  DATA_W  read data; meaningful only when valid.
- sx_readdatavalid  out  1  one-cycle pulse per accepted read.
- sx_waitrequest  out  1  command not accepted this cycle.

## Operation
- `stall = reset_req | ~clken | clearing`. `sx_waitrequest = stall`. Asserted asynchronously while `reset` is high.
- Accept: command accepted on a rising edge with `chipselect & (read | write) & ~waitrequest`.
- Read and write asserted together: treated as a write only; no `readdatavalid` is produced.
- Writes update only the bytes whose `byteenable` bit is set. `byteenable = 0` is a legal no-op.
- Out-of-range address (`address ≥ DEPTH`): write is discarded. Read is accepted and returns all zeros with normal valid timing.
- Collision, both ports writing the same address in the same cycle: s1 wins for every byte it enables. s2 bytes not enabled by s1 are written.
- Mixed-port read-during-write to the same address: the read returns the old data.
- Same-port read-during-write cannot occur, because read+write is treated as write only.
- Each port has a READ_LATENCY-deep valid/data shift pipeline. Reads already in flight complete even if `stall` rises after acceptance. The pipeline is never frozen by `clken`, so no read is lost.
- Back-to-back reads: one accepted per cycle per port, yielding one valid pulse per cycle.

## Timing
- Reset values: `sx_readdata = 0`, `sx_readdatavalid = 0`, `sx_waitrequest = 1`. The valid pipeline is cleared, and the clear FSM enters CLEAR (or READY when compiled out).
- Read accepted at edge N: `readdatavalid` is high during the cycle after edge N+READ_LATENCY-1. Latency 1 means valid in the cycle after acceptance.
- Write accepted at edge N: the data is visible to a read accepted at edge N+1 on either port.
- `reset` asserted mid-read: the in-flight valid is dropped.
- `reset` asserted mid-sweep: the sweep restarts from address 0 after deassertion.

## Configuration
- Macro: SIMPLE_SYSTEM_ONCHIP_RAM_CLEAR_EN.
- Defined: a two-state FSM (CLEAR, READY) is compiled in.
  - CLEAR writes zeros to address 0..DEPTH-1, one word per cycle, through the s1 write path. Its counter is ceil(log2(DEPTH+1)) bits, so it holds DEPTH without wrapping.
  - `clearing` is high in CLEAR, and the counter advances only while `reset_req = 0` and `clken = 1`.
  - After writing word DEPTH-1, the FSM moves to READY, `waitrequest` drops on the next cycle (absent other stall), and it stays in READY until reset.
  - INIT_FILE is ignored.
- Undefined: no FSM, `clearing = 0`, and the array is initialised from INIT_FILE. `waitrequest` deasserts the first cycle after reset release when `clken = 1` and `reset_req = 0`.

## Test plan
- Basic read, READY, READY_LATENCY=1: s1 writes 0x0123456789ABCDEF to address 5 with `byteenable = 0xFF`, then reads address 5 → `s1_readdatavalid` one cycle after acceptance, `s1_readdata = 0x0123456789ABCDEF`. Repeat with READ_LATENCY=2 → valid two cycles after acceptance.
- Byte enables and cross-port visibility: s2 writes 0xFFFF…FF to address 5 with `byteenable = 0x0F`, then s1 reads address 5 → 0x01234567FFFFFFFF.
- Same-address collision and mixed-port read-during-write:
  - In one cycle, s1 writes 0xAA…AA with `be = 0xF0` and s2 writes 0x55…55 with `be = 0xFF` to address 9 → a later read of address 9 returns 0xAAAAAAAA55555555.
  - s2 reads address 9 in the same cycle s1 writes it → s2 gets the prior value.
- Stall and out-of-range:
  - `clken = 0` for 3 cycles with `s1_read` held → `waitrequest` high for 3 cycles, exactly one valid after release.
  - Read of address DEPTH → data 0 with valid.
  - Write to address DEPTH → array unchanged.
- Clear sweep (macro defined, DEPTH = 16):
  - Release reset → `waitrequest` high for exactly 16 cycles, then low; reading all 16 addresses returns 0.
  - Pulse `reset` at sweep cycle 7 → the full 16-cycle sweep restarts.
- Throughput: s1 and s2 each issue 8 back-to-back reads → 8 consecutive valid pulses per port, with data in issue order.
